// File: rtl/nf10_axis_rr_arbiter_if.sv
// AXI4-Stream bundle used for the four ingress ports and the merged egress
// of nf10_axis_rr_arbiter.
interface nf10_axis_rr_arbiter_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_axis_rr_arbiter.sv
// Packet-granular round-robin merge of four AXI4-Stream ingress ports into one
// registered egress stream. Define NF10_ARB_PKT_CNT_EN for per-port packet counters.
module nf10_axis_rr_arbiter #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_PORTS        = 4
) (
  input  logic                          axi_aclk,
  input  logic                          axi_resetn,
  nf10_axis_rr_arbiter_if.slave         s_axis_0,
  nf10_axis_rr_arbiter_if.slave         s_axis_1,
  nf10_axis_rr_arbiter_if.slave         s_axis_2,
  nf10_axis_rr_arbiter_if.slave         s_axis_3,
  nf10_axis_rr_arbiter_if.master        m_axis,
  output logic [31:0]                   pkt_cnt_0,
  output logic [31:0]                   pkt_cnt_1,
  output logic [31:0]                   pkt_cnt_2,
  output logic [31:0]                   pkt_cnt_3
);

  localparam int STRB_WIDTH = C_AXIS_DATA_WIDTH / 8;
  localparam int PAY_WIDTH  = C_AXIS_DATA_WIDTH + STRB_WIDTH + C_AXIS_TUSER_WIDTH + 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state_reg, state_next;
  logic [1:0]             rr_ptr_reg, rr_ptr_next;
  logic [1:0]             cur_port_reg, cur_port_next;
  logic [1:0]             pick;
  logic                   out_valid_reg;
  logic [PAY_WIDTH-1:0]   out_pay_reg;
  logic                   load_en;
  logic                   accept;
  logic                   accept_last;

  // Payload packed as {tdata, tstrb, tuser, tlast}; bit 0 is tlast.
  logic [PAY_WIDTH-1:0]   s_pay [C_NUM_PORTS];
  logic [C_NUM_PORTS-1:0] s_valid;
  logic [C_NUM_PORTS-1:0] s_ready;
  logic [31:0]            pkt_cnt [C_NUM_PORTS];

  assign s_pay[0] = {s_axis_0.tdata, s_axis_0.tstrb, s_axis_0.tuser, s_axis_0.tlast};
  assign s_pay[1] = {s_axis_1.tdata, s_axis_1.tstrb, s_axis_1.tuser, s_axis_1.tlast};
  assign s_pay[2] = {s_axis_2.tdata, s_axis_2.tstrb, s_axis_2.tuser, s_axis_2.tlast};
  assign s_pay[3] = {s_axis_3.tdata, s_axis_3.tstrb, s_axis_3.tuser, s_axis_3.tlast};
  assign s_valid  = {s_axis_3.tvalid, s_axis_2.tvalid, s_axis_1.tvalid, s_axis_0.tvalid};

  assign s_axis_0.tready = s_ready[0];
  assign s_axis_1.tready = s_ready[1];
  assign s_axis_2.tready = s_ready[2];
  assign s_axis_3.tready = s_ready[3];

  assign load_en     = !out_valid_reg || m_axis.tready;
  assign accept      = |(s_ready & s_valid);
  assign accept_last = accept && s_pay[cur_port_reg][0];

  // First requester after rr_ptr; descending scan lets the nearest one win.
  always_comb begin
    logic [1:0] idx;
    idx  = '0;
    pick = rr_ptr_reg + 2'd1;
    for (int i = 4; i >= 1; i--) begin
      idx = rr_ptr_reg + 2'(i);
      if (s_valid[idx]) pick = idx;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= 2'd3;
      cur_port_reg <= 2'd0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      cur_port_reg <= cur_port_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    cur_port_next = cur_port_reg;
    case (state_reg)
      IDLE: begin
        if (|s_valid) begin
          state_next    = BUSY;
          cur_port_next = pick;
        end
      end
      BUSY: begin
        if (accept_last) begin
          state_next  = IDLE;
          rr_ptr_next = cur_port_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready = '0;
    for (int i = 0; i < C_NUM_PORTS; i++) begin
      s_ready[i] = (state_reg == BUSY) && (cur_port_reg == 2'(i)) && load_en;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      out_valid_reg <= 1'b0;
      out_pay_reg   <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_pay_reg   <= s_pay[cur_port_reg];
    end else if (m_axis.tready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign m_axis.tvalid = out_valid_reg;
  assign {m_axis.tdata, m_axis.tstrb, m_axis.tuser, m_axis.tlast} = out_pay_reg;

  genvar gi;
`ifdef NF10_ARB_PKT_CNT_EN
  for (gi = 0; gi < C_NUM_PORTS; gi++) begin : gen_pkt_cnt
    logic [31:0] cnt_reg;
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
        cnt_reg <= 32'h0;
      end else if (s_ready[gi] && s_valid[gi] && s_pay[gi][0]) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
    assign pkt_cnt[gi] = cnt_reg;
  end
`else
  for (gi = 0; gi < C_NUM_PORTS; gi++) begin : gen_pkt_cnt_off
    assign pkt_cnt[gi] = 32'h0;
  end
`endif

  assign pkt_cnt_0 = pkt_cnt[0];
  assign pkt_cnt_1 = pkt_cnt[1];
  assign pkt_cnt_2 = pkt_cnt[2];
  assign pkt_cnt_3 = pkt_cnt[3];

  a_one_grant: assert property (@(posedge axi_aclk) disable iff (!axi_resetn) $onehot0(s_ready));

endmodule
